// File: rtl/xup_inv_share_ctrl_pkg.sv
// Shared definitions for the inverter-sharing controller and its arbiter.
package xup_inv_share_ctrl_pkg;

    // Encodings kept identical to the legacy state values.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xup_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr.
module xup_rr_arbiter
    import xup_inv_share_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    localparam int unsigned N = NREQ;

    logic [IDW-1:0] pos;

    // Scan ptr, ptr+1, ... with wrap; the first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IDW'((32'(ptr) + k) % N);
            if (!any && req[pos]) begin
                onehot[pos] = 1'b1;
                idx         = pos;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xup_inv_share_ctrl.sv
// Sequences NREQ requesters through one shared external inverter vector:
// grant, wait for the inverter to settle, capture, pulse done.
module xup_inv_share_ctrl
    import xup_inv_share_ctrl_pkg::*;
#(
    parameter  int SIZE       = 8,
    parameter  int NREQ       = 4,
    parameter  int SETTLE_CYC = 2,
    localparam int IDW        = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] din,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [SIZE-1:0]      dout,
    output logic [IDW-1:0]       dout_id,
    output logic                 busy,
    output logic [SIZE-1:0]      inv_a,
    input  logic [SIZE-1:0]      inv_y
);

    if (NREQ < 2 || NREQ > 16 || SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_param_check
        $error("xup_inv_share_ctrl: NREQ must be 2..16 and SETTLE_CYC 1..255");
    end

    localparam logic [7:0]     CNT_INIT = 8'(SETTLE_CYC - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [7:0]      cnt;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic            grant_now;
    logic            capture_now;

    xup_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and the grant/capture strobes for the datapath.
    always_comb begin
        state_nxt   = state;
        grant_now   = 1'b0;
        capture_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    grant_now = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    capture_now = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, settle counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            cur_id  <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            dout    <= '0;
            dout_id <= '0;
            inv_a   <= '0;
        end else begin
            done <= '0;
            if (grant_now) begin
                gnt    <= win_oh;
                inv_a  <= din[win_idx*SIZE +: SIZE];
                cnt    <= CNT_INIT;
                cur_id <= win_idx;
                ptr    <= (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
            end else if (state == ST_SETTLE) begin
                if (capture_now) begin
                    dout    <= inv_y;
                    dout_id <= cur_id;
                    done    <= gnt;
                    gnt     <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Busy covers the whole operation after the grant, including the done cycle.
    assign busy = (state == ST_SETTLE) || (state == ST_DONE);

endmodule

// File: tb/tb_xup_inv_share_ctrl.sv
// Scoreboard bench for xup_inv_share_ctrl: one instance with SETTLE_CYC=2 and
// one with SETTLE_CYC=1, each driving a delayed inverter model.
module tb_xup_inv_share_ctrl;

    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int SC0  = 2;
    localparam int SC1  = 1;

    typedef struct {
        int unsigned id;
        logic [7:0]  val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  req = '0, gnt, done;
    logic [31:0] din = '0;
    logic [7:0]  dout, inv_a, inv_y;
    logic [1:0]  dout_id;
    logic        busy;

    logic [3:0]  req1 = '0, gnt1, done1;
    logic [31:0] din1 = '0;
    logic [7:0]  dout1, inv_a1, inv_y1;
    logic [1:0]  dout_id1;
    logic        busy1;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    int unsigned gq[$], gq1[$];
    exp_t        dq[$], dq1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared inverter vector (SIZE=8, DELAY=3) as a delayed model.
    assign #3 inv_y  = ~inv_a;
    assign #3 inv_y1 = ~inv_a1;

    xup_inv_share_ctrl #(.SIZE(SIZE), .NREQ(NREQ), .SETTLE_CYC(SC0)) dut (
        .clk(clk), .reset(rst), .req(req), .din(din), .gnt(gnt), .done(done),
        .dout(dout), .dout_id(dout_id), .busy(busy), .inv_a(inv_a), .inv_y(inv_y)
    );

    xup_inv_share_ctrl #(.SIZE(SIZE), .NREQ(NREQ), .SETTLE_CYC(SC1)) dut1 (
        .clk(clk), .reset(rst), .req(req1), .din(din1), .gnt(gnt1), .done(done1),
        .dout(dout1), .dout_id(dout_id1), .busy(busy1), .inv_a(inv_a1), .inv_y(inv_y1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic put(input int unsigned i, input logic [7:0] v);
        din[i*8 +: 8] = v;
    endtask

    task automatic expect_op(input int unsigned id, input logic [7:0] res);
        gq.push_back(id);
        dq.push_back('{id, res});
    endtask

    // Monitor for the SETTLE_CYC=2 instance.
    logic [3:0]  pg = '0;
    int unsigned g_cyc = 0;
    int unsigned e_id;
    exp_t        e_op;
    always @(negedge clk) begin
        if (rst) begin
            pg = '0;
        end else begin
            if (gnt != '0 && pg == '0) begin
                g_cyc = cyc;
                if (gq.size() == 0) chk("unexpected_gnt", 32'(gnt), 0);
                else begin
                    e_id = gq.pop_front();
                    chk("gnt_order", 32'(gnt), 32'(1) << e_id);
                end
            end
            if (done != '0) begin
                chk("gnt_done_overlap", 32'(gnt & ~done), 0);
                if (dq.size() == 0) chk("unexpected_done", 32'(done), 0);
                else begin
                    e_op = dq.pop_front();
                    chk("done_onehot", 32'(done), 32'(1) << e_op.id);
                    chk("dout", 32'(dout), 32'(e_op.val));
                    chk("dout_id", 32'(dout_id), e_op.id);
                    chk("gnt_to_done", cyc - g_cyc, SC0);
                end
            end
            pg = gnt;
        end
    end

    // Monitor for the SETTLE_CYC=1 instance; also tracks inv_y stability.
    logic [3:0]  pg1 = '0;
    int unsigned g_cyc1 = 0;
    logic [7:0]  y_at_gnt1 = '0;
    int unsigned e_id1;
    exp_t        e_op1;
    always @(negedge clk) begin
        if (rst) begin
            pg1 = '0;
        end else begin
            if (gnt1 != '0 && pg1 == '0) begin
                g_cyc1    = cyc;
                y_at_gnt1 = inv_y1;
                if (gq1.size() == 0) chk("unexpected_gnt1", 32'(gnt1), 0);
                else begin
                    e_id1 = gq1.pop_front();
                    chk("gnt1_order", 32'(gnt1), 32'(1) << e_id1);
                end
            end
            if (done1 != '0) begin
                if (dq1.size() == 0) chk("unexpected_done1", 32'(done1), 0);
                else begin
                    e_op1 = dq1.pop_front();
                    chk("done1_onehot", 32'(done1), 32'(1) << e_op1.id);
                    chk("dout1", 32'(dout1), 32'(e_op1.val));
                    chk("dout_id1", 32'(dout_id1), e_op1.id);
                    chk("gnt1_to_done1", cyc - g_cyc1, SC1);
                    chk("inv_y1_stable", 32'(inv_y1), 32'(y_at_gnt1));
                end
            end
            pg1 = gnt1;
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy) chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_gnt(input int unsigned id);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[id] && n < 20);
        if (!gnt[id]) chk("gnt_timeout", 32'(gnt), 32'(1) << id);
    endtask

    // Hold mask until n done pulses are seen, checking their spacing.
    task automatic run_ops(input logic [3:0] mask, input int unsigned n);
        int unsigned seen = 0, last = 0, budget = 0;
        @(negedge clk);
        req = mask;
        while (seen < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (done != '0) begin
                if (seen > 0) chk("done_spacing", cyc - last, SC0 + 2);
                last = cyc;
                seen++;
            end
        end
        req = '0;
        if (seen < n) chk("run_timeout", seen, n);
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_id", 32'(dout_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inv_a", 32'(inv_a), 0);
        chk("rst_inv_a1", 32'(inv_a1), 0);
        chk("rst_busy1", 32'(busy1), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // Single request.
        put(0, 8'hA5);
        expect_op(0, 8'h5A);
        run_ops(4'b0001, 1);

        // Simultaneous requests from a fresh pointer.
        do_reset();
        put(0, 8'h00); put(1, 8'h10); put(2, 8'h20); put(3, 8'h30);
        expect_op(0, 8'hFF); expect_op(1, 8'hEF); expect_op(2, 8'hDF);
        expect_op(3, 8'hCF); expect_op(0, 8'hFF);
        run_ops(4'b1111, 5);

        // Pointer wrap: after requester 3, requester 0 beats 3.
        put(3, 8'h81);
        expect_op(3, 8'h7E);
        run_ops(4'b1000, 1);
        put(0, 8'h42);
        expect_op(0, 8'hBD); expect_op(3, 8'h7E);
        run_ops(4'b1001, 2);

        // Request dropped and operand changed during SETTLE.
        put(2, 8'h3C);
        expect_op(2, 8'hC3);
        @(negedge clk);
        req = 4'b0100;
        wait_gnt(2);
        req = '0;
        put(2, 8'hC3);
        @(negedge clk);
        chk("inv_a_hold", 32'(inv_a), 32'h3C);
        wait_idle();

        // Reset one cycle after the grant aborts the operation.
        put(1, 8'h77);
        gq.push_back(1);
        @(negedge clk);
        req = 4'b0010;
        wait_gnt(1);
        req = '0;
        @(negedge clk);
        chk("busy_settle", 32'(busy), 1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(done), 0);
        end
        put(0, 8'h01); put(2, 8'h80);
        expect_op(0, 8'hFE); expect_op(2, 8'h7F);
        run_ops(4'b0101, 2);

        // Edge operands on the SETTLE_CYC=1 instance.
        din1[7:0]  = 8'h00;
        din1[15:8] = 8'hFF;
        gq1.push_back(0); dq1.push_back('{0, 8'hFF});
        gq1.push_back(1); dq1.push_back('{1, 8'h00});
        @(negedge clk);
        req1 = 4'b0011;
        begin
            int unsigned seen = 0, budget = 0;
            while (seen < 2 && budget < 50) begin
                @(negedge clk);
                budget++;
                if (done1 != '0) seen++;
            end
            req1 = '0;
            if (seen < 2) chk("run1_timeout", seen, 2);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", gq.size() + dq.size() + gq1.size() + dq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
